// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Brief    : MIPS instruction-fetch stage. Owns the PC, talks to a
//            variable-latency instruction memory, honours hazard stalls and
//            branch/jump redirects from ID, and feeds the IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        hd_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        jump_i,
    input  logic [25:0] jump_addr_i,
    input  logic [31:0] id_pc4_i,
    output logic        imem_req_o,
    output logic [31:0] pc_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_inst_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        valid_o,
    output logic        flush_o
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_tgt;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic        w_valid;

    // Redirect decode: a stalled ID stage must not steer the PC; jump beats branch.
    always_comb begin
        w_redirect = !hd_i && (jump_i || branch_i);
        if (jump_i) begin
            w_target = {id_pc4_i[31:28], jump_addr_i, 2'b00};
        end else begin
            w_target = {branch_addr_i[31:2], 2'b00};
        end
        w_pc_plus4 = r_pc + 32'd4;
    end

    // PC / pending-target / state update. In DRAIN the old request must finish
    // at the old address before the PC may move, so the target is parked in r_tgt.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
            r_pc    <= RESET_PC;
            r_tgt   <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start_i) begin
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (hd_i) begin
                        r_pc <= r_pc;
                    end else if (w_redirect) begin
                        if (imem_ready_i) begin
                            r_pc <= w_target;
                        end else begin
                            r_tgt   <= w_target;
                            r_state <= c_ST_DRAIN;
                        end
                    end else if (imem_ready_i) begin
                        r_pc <= w_pc_plus4;
                    end
                end
                c_ST_DRAIN: begin
                    if (w_redirect) begin
                        r_tgt <= w_target;
                    end
                    if (imem_ready_i) begin
                        r_pc    <= w_redirect ? w_target : r_tgt;
                        r_state <= c_ST_RUN;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Outputs toward memory and IF/ID; a held IF/ID (hd_i) is never flushed.
    always_comb begin
        w_valid     = (r_state == c_ST_RUN) && imem_ready_i && !hd_i && !w_redirect;
        valid_o     = w_valid;
        inst_o      = w_valid ? imem_inst_i : 32'd0;
        inst_addr_o = w_pc_plus4;
        flush_o     = !hd_i && !w_valid;
        imem_req_o  = (r_state != c_ST_IDLE);
        pc_o        = r_pc;
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Brief    : Directed, table-driven bench for if_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        hd_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = 32'd0;
    logic        jump_i = 1'b0;
    logic [25:0] jump_addr_i = 26'd0;
    logic [31:0] id_pc4_i = 32'd0;
    logic        imem_req_o;
    logic [31:0] pc_o;
    logic        imem_ready_i = 1'b0;
    logic [31:0] imem_inst_i = 32'd0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        valid_o;
    logic        flush_o;

    int errors = 0;
    int checks = 0;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .hd_i(hd_i),
        .branch_i(branch_i), .branch_addr_i(branch_addr_i),
        .jump_i(jump_i), .jump_addr_i(jump_addr_i), .id_pc4_i(id_pc4_i),
        .imem_req_o(imem_req_o), .pc_o(pc_o),
        .imem_ready_i(imem_ready_i), .imem_inst_i(imem_inst_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .valid_o(valid_o), .flush_o(flush_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        start, hd, br, jmp, rdy;
        logic [31:0] baddr;
        logic [25:0] jaddr;
        logic [31:0] idpc4;
        logic [31:0] inst;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_inst;
        logic        e_flush;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic start, logic hd, logic br, logic [31:0] baddr,
                                logic jmp, logic [25:0] jaddr, logic [31:0] idpc4,
                                logic rdy, logic [31:0] inst,
                                logic e_req, logic [31:0] e_pc, logic e_valid,
                                logic [31:0] e_inst, logic e_flush);
        vec_t v;
        v.start = start; v.hd = hd; v.br = br; v.baddr = baddr; v.jmp = jmp;
        v.jaddr = jaddr; v.idpc4 = idpc4; v.rdy = rdy; v.inst = inst;
        v.e_req = e_req; v.e_pc = e_pc; v.e_valid = e_valid;
        v.e_inst = e_inst; v.e_flush = e_flush;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Compare every output against the expected values.
    task automatic chk_all(int idx, logic e_req, logic [31:0] e_pc, logic e_valid,
                           logic [31:0] e_inst, logic e_flush);
        chk("imem_req_o", idx, {31'd0, imem_req_o}, {31'd0, e_req});
        chk("pc_o", idx, pc_o, e_pc);
        chk("valid_o", idx, {31'd0, valid_o}, {31'd0, e_valid});
        chk("inst_o", idx, inst_o, e_inst);
        chk("flush_o", idx, {31'd0, flush_o}, {31'd0, e_flush});
        chk("inst_addr_o", idx, inst_addr_o, e_pc + 32'd4);
    endtask

    task automatic apply(vec_t v);
        start_i = v.start; hd_i = v.hd; branch_i = v.br; branch_addr_i = v.baddr;
        jump_i = v.jmp; jump_addr_i = v.jaddr; id_pc4_i = v.idpc4;
        imem_ready_i = v.rdy; imem_inst_i = v.inst;
    endtask

    initial begin
        // --- vector table, applied one per cycle starting right after reset ---
        //           start hd br baddr          jmp jaddr          idpc4          rdy inst           req pc             vld inst           flush
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 26'h0,        32'h0,         1, 32'h1234_5678, 0, 32'h0000_0000, 0, 32'h0,         1)); // 0 idle, start
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,        32'h0,         1, 32'h2008_0001, 1, 32'h0000_0000, 1, 32'h2008_0001, 0)); // 1
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,        32'h0,         1, 32'h2009_0002, 1, 32'h0000_0004, 1, 32'h2009_0002, 0)); // 2
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 26'h0,        32'h0,         1, 32'h200A_0003, 1, 32'h0000_0008, 0, 32'h0,         0)); // 3 stall
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 26'h0,        32'h0,         1, 32'h200A_0003, 1, 32'h0000_0008, 0, 32'h0,         0)); // 4 stall
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,        32'h0,         1, 32'h200A_0003, 1, 32'h0000_0008, 1, 32'h200A_0003, 0)); // 5 resume
        vecs.push_back(mk(0, 0, 1, 32'h40,        0, 26'h0,        32'h0,         1, 32'h200B_0004, 1, 32'h0000_000C, 0, 32'h0,         1)); // 6 branch
        vecs.push_back(mk(0, 0, 1, 32'h43,        1, 26'h10,       32'h1000_0000, 1, 32'h3333_3333, 1, 32'h0000_0040, 0, 32'h0,         1)); // 7 jump wins
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,        32'h0,         1, 32'h1111_1111, 1, 32'h1000_0040, 1, 32'h1111_1111, 0)); // 8
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 26'h4,        32'h0,         1, 32'h4444_4444, 1, 32'h1000_0044, 0, 32'h0,         1)); // 9 jump to 0x10
        vecs.push_back(mk(0, 0, 1, 32'h80,        0, 26'h0,        32'h0,         0, 32'h0,         1, 32'h0000_0010, 0, 32'h0,         1)); // 10 -> DRAIN
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,        32'h0,         0, 32'h0,         1, 32'h0000_0010, 0, 32'h0,         1)); // 11 wait
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,        32'h0,         1, 32'hDEAD_BEEF, 1, 32'h0000_0010, 0, 32'h0,         1)); // 12 discard
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,        32'h0,         1, 32'h2222_2222, 1, 32'h0000_0080, 1, 32'h2222_2222, 0)); // 13
        vecs.push_back(mk(0, 0, 1, 32'h100,       0, 26'h0,        32'h0,         0, 32'h0,         1, 32'h0000_0084, 0, 32'h0,         1)); // 14 -> DRAIN
        vecs.push_back(mk(0, 0, 1, 32'hC0,        0, 26'h0,        32'h0,         0, 32'h0,         1, 32'h0000_0084, 0, 32'h0,         1)); // 15 overwrite
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,        32'h0,         0, 32'h0,         1, 32'h0000_0084, 0, 32'h0,         1)); // 16
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,        32'h0,         1, 32'h5555_5555, 1, 32'h0000_0084, 0, 32'h0,         1)); // 17 complete
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,        32'h0,         1, 32'h6666_6666, 1, 32'h0000_00C0, 1, 32'h6666_6666, 0)); // 18
        vecs.push_back(mk(0, 1, 1, 32'h200,       0, 26'h0,        32'h0,         1, 32'h7777_7777, 1, 32'h0000_00C4, 0, 32'h0,         0)); // 19 stalled branch
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,        32'h0,         1, 32'h7777_7777, 1, 32'h0000_00C4, 1, 32'h7777_7777, 0)); // 20
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,        32'h0,         1, 32'h8888_8888, 1, 32'h0000_00C8, 1, 32'h8888_8888, 0)); // 21
        vecs.push_back(mk(0, 0, 1, 32'h300,       0, 26'h0,        32'h0,         0, 32'h0,         1, 32'h0000_00CC, 0, 32'h0,         1)); // 22 -> DRAIN
        vecs.push_back(mk(0, 0, 1, 32'h400,       0, 26'h0,        32'h0,         1, 32'h9999_9999, 1, 32'h0000_00CC, 0, 32'h0,         1)); // 23 same-cycle
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,        32'h0,         1, 32'hAAAA_AAAA, 1, 32'h0000_0400, 1, 32'hAAAA_AAAA, 0)); // 24
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 26'h3FF_FFFF, 32'hF000_0000, 1, 32'h0,         1, 32'h0000_0404, 0, 32'h0,         1)); // 25 jump top
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,        32'h0,         1, 32'hBBBB_BBBB, 1, 32'hFFFF_FFFC, 1, 32'hBBBB_BBBB, 0)); // 26 wrap
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0,        32'h0,         1, 32'hCCCC_CCCC, 1, 32'h0000_0000, 1, 32'hCCCC_CCCC, 0)); // 27
        vecs.push_back(mk(0, 0, 1, 32'h500,       0, 26'h0,        32'h0,         0, 32'h0,         1, 32'h0000_0004, 0, 32'h0,         1)); // 28 -> DRAIN

        // Reset state, checked while reset is held with no clock edge needed.
        @(negedge clk_i);
        #1;
        chk_all(-1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) @(negedge clk_i);
            apply(vecs[i]);
            #1;
            chk_all(i, vecs[i].e_req, vecs[i].e_pc, vecs[i].e_valid,
                    vecs[i].e_inst, vecs[i].e_flush);
        end

        // Still waiting in DRAIN: reset asynchronously, outputs must drop at once.
        @(negedge clk_i);
        start_i = 1'b0; hd_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0;
        imem_ready_i = 1'b0;
        #1;
        chk("pre-reset pc_o", 100, pc_o, 32'h0000_0004);
        chk("pre-reset req", 100, {31'd0, imem_req_o}, 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        chk_all(101, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b0;
        imem_ready_i = 1'b1;
        imem_inst_i  = 32'h0BAD_0BAD;

        // No start: no fetch, PC stays at reset value.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            #1;
            chk_all(102 + k, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        end

        // Start again, first instruction the following cycle.
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        imem_inst_i = 32'h2008_0001;
        #1;
        chk_all(110, 1'b1, 32'h0, 1'b1, 32'h2008_0001, 1'b0);
        @(negedge clk_i);
        imem_inst_i = 32'h2009_0002;
        #1;
        chk_all(111, 1'b1, 32'h4, 1'b1, 32'h2009_0002, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
